// File: rtl/ngp_imem_loader.sv
// Instruction memory for ngp_core with a byte-stream program loader.
// Frames are 5A, LEN lo, LEN hi, then LEN little-endian words; core_hold_o stays high until a frame completes.
module ngp_imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] addr_i,
    output logic [15:0] instruction_o,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic        core_hold_o,
    output logic        loading_o,
    output logic        error_o
);

    localparam int          DEPTH    = 2 ** ADDR_W;
    localparam logic [16:0] DEPTH17  = 17'(DEPTH);
    localparam logic [7:0]  START_B  = 8'h5A;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA_LO,
        DATA_HI,
        RUN,
        ERR
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [ADDR_W:0]   wptr_q, wptr_d;
    logic [7:0]        lo_q, lo_d;
    logic [ADDR_W:0]   wptrInc;
    logic [15:0]       fullLen;
    logic              accept;
    logic              memWe;
    logic [15:0]       addrHigh;

    logic [15:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            len_q   <= '0;
            wptr_q  <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            wptr_q  <= wptr_d;
            lo_q    <= lo_d;
        end
    end

    // Memory is deliberately left out of reset so a reload only overwrites words below LEN.
    always_ff @(posedge clk_i) begin
        if (memWe) begin
            mem_q[wptr_q[ADDR_W-1:0]] <= {rx_data_i, lo_q};
        end
    end

    assign accept  = rx_valid_i && rx_ready_o;
    assign wptrInc = wptr_q + 1'b1;
    assign fullLen = {rx_data_i, len_q[7:0]};

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        wptr_d  = wptr_q;
        lo_d    = lo_q;
        memWe   = 1'b0;
        if (accept) begin
            case (state_q)
                IDLE, RUN: begin
                    if (rx_data_i == START_B) begin
                        state_d = LEN_LO;
                    end
                end
                LEN_LO: begin
                    len_d[7:0] = rx_data_i;
                    state_d    = LEN_HI;
                end
                LEN_HI: begin
                    len_d[15:8] = rx_data_i;
                    wptr_d      = '0;
                    // 17-bit compare so a length of exactly DEPTH is accepted.
                    if (fullLen == 16'd0) begin
                        state_d = RUN;
                    end else if ({1'b0, fullLen} > DEPTH17) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA_LO;
                    end
                end
                DATA_LO: begin
                    lo_d    = rx_data_i;
                    state_d = DATA_HI;
                end
                DATA_HI: begin
                    memWe  = 1'b1;
                    wptr_d = wptrInc;
                    if (17'(wptrInc) == {1'b0, len_q}) begin
                        state_d = RUN;
                    end else begin
                        state_d = DATA_LO;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        rx_ready_o  = 1'b1;
        core_hold_o = 1'b1;
        loading_o   = 1'b0;
        error_o     = 1'b0;
        case (state_q)
            LEN_LO, LEN_HI, DATA_LO, DATA_HI: loading_o = 1'b1;
            RUN: core_hold_o = 1'b0;
            ERR: begin
                rx_ready_o = 1'b0;
                error_o    = 1'b1;
            end
            default: ;
        endcase
    end

    assign addrHigh      = addr_i >> ADDR_W;
    assign instruction_o = (addrHigh == 16'd0) ? mem_q[addr_i[ADDR_W-1:0]] : 16'h0000;

endmodule

// File: tb/tb_ngp_imem_loader.sv
// Directed bench for ngp_imem_loader: frames are driven byte by byte and fetches
// are checked against a bench-side memory model through an expected-value queue.
module tb_ngp_imem_loader;

    logic        clk;
    logic        rst;
    logic [15:0] addr;
    logic [15:0] instruction;
    logic [7:0]  rxData;
    logic        rxValid;
    logic        rxReady;
    logic        coreHold;
    logic        loading;
    logic        errorFlag;

    int checks = 0;
    int errors = 0;

    logic [15:0] modelMem [256];
    logic [15:0] expQ [$];

    ngp_imem_loader #(.ADDR_W(8)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .addr_i       (addr),
        .instruction_o(instruction),
        .rx_data_i    (rxData),
        .rx_valid_i   (rxValid),
        .rx_ready_o   (rxReady),
        .core_hold_o  (coreHold),
        .loading_o    (loading),
        .error_o      (errorFlag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One byte offered for exactly one cycle; outputs are sampled 1 time unit after the edge.
    task automatic applyStimulus(input logic [7:0] b);
        @(negedge clk);
        rxData  = b;
        rxValid = 1'b1;
        @(posedge clk);
        #1;
        rxValid = 1'b0;
    endtask

    task automatic sendWord(input int idx, input logic [15:0] w);
        applyStimulus(w[7:0]);
        applyStimulus(w[15:8]);
        modelMem[idx] = w;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic readWord(input string tag, input logic [15:0] a);
        logic [15:0] exp;
        addr = a;
        if (a < 16'h0100) expQ.push_back(modelMem[a[7:0]]);
        else expQ.push_back(16'h0000);
        #1;
        exp = expQ.pop_front();
        checkOutput(tag, instruction, exp);
    endtask

    task automatic checkFlags(input string tag, input logic hold, input logic load, input logic err, input logic rdy);
        checkOutput({tag, "_hold"}, 16'(coreHold), 16'(hold));
        checkOutput({tag, "_loading"}, 16'(loading), 16'(load));
        checkOutput({tag, "_error"}, 16'(errorFlag), 16'(err));
        checkOutput({tag, "_ready"}, 16'(rxReady), 16'(rdy));
    endtask

    initial begin
        rst     = 1'b0;
        addr    = 16'h0000;
        rxData  = 8'h00;
        rxValid = 1'b0;

        doReset();
        checkFlags("reset", 1'b1, 1'b0, 1'b0, 1'b1);

        // Basic three-word frame
        applyStimulus(8'h5A);
        checkFlags("f1_start", 1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(8'h03);
        applyStimulus(8'h00);
        checkFlags("f1_len", 1'b1, 1'b1, 1'b0, 1'b1);
        sendWord(0, 16'h1234);
        checkOutput("f1_hold_w0", 16'(coreHold), 16'd1);
        readWord("f1_early_w0", 16'h0000);
        sendWord(1, 16'h5678);
        checkOutput("f1_hold_w1", 16'(coreHold), 16'd1);
        applyStimulus(8'hBC);
        checkOutput("f1_hold_lo2", 16'(coreHold), 16'd1);
        addr = 16'h0002;
        modelMem[2] = 16'h9ABC;
        applyStimulus(8'h9A);
        checkFlags("f1_done", 1'b0, 1'b0, 1'b0, 1'b1);
        readWord("f1_same_cycle_w2", 16'h0002);
        readWord("f1_w0", 16'h0000);
        readWord("f1_w1", 16'h0001);
        readWord("f1_out_of_range", 16'h0100);
        readWord("f1_out_of_range_hi", 16'h8001);

        // Zero-length frame from RUN
        applyStimulus(8'h5A);
        checkOutput("zl_hold_start", 16'(coreHold), 16'd1);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        checkFlags("zl_done", 1'b0, 1'b0, 1'b0, 1'b1);
        readWord("zl_w0", 16'h0000);
        readWord("zl_w2", 16'h0002);

        // Non-start bytes in RUN are ignored
        applyStimulus(8'h33);
        checkFlags("run_junk", 1'b0, 1'b0, 1'b0, 1'b1);

        // Reload one word from RUN
        applyStimulus(8'h5A);
        checkFlags("rl_start", 1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(8'h01);
        applyStimulus(8'h00);
        sendWord(0, 16'hEEEE);
        checkFlags("rl_done", 1'b0, 1'b0, 1'b0, 1'b1);
        readWord("rl_w0", 16'h0000);
        readWord("rl_w1", 16'h0001);
        readWord("rl_w2", 16'h0002);

        // Garbage in IDLE, then a frame with rx_valid gaps inside words
        doReset();
        applyStimulus(8'h00);
        applyStimulus(8'hFF);
        applyStimulus(8'h11);
        checkFlags("garbage", 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'h5A);
        applyStimulus(8'h02);
        idleCycles(2);
        applyStimulus(8'h00);
        applyStimulus(8'hB2);
        idleCycles(3);
        checkFlags("gap_mid", 1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(8'hA1);
        modelMem[0] = 16'hA1B2;
        applyStimulus(8'hD4);
        idleCycles(1);
        applyStimulus(8'hC3);
        modelMem[1] = 16'hC3D4;
        checkFlags("gap_done", 1'b0, 1'b0, 1'b0, 1'b1);
        readWord("gap_w0", 16'h0000);
        readWord("gap_w1", 16'h0001);
        readWord("gap_w2_old", 16'h0002);

        // Reset mid-frame after the low byte of the third word
        applyStimulus(8'h5A);
        applyStimulus(8'h03);
        applyStimulus(8'h00);
        sendWord(0, 16'h0F0F);
        sendWord(1, 16'h7E81);
        applyStimulus(8'h44);
        doReset();
        checkFlags("midrst", 1'b1, 1'b0, 1'b0, 1'b1);
        readWord("midrst_w0", 16'h0000);
        readWord("midrst_w1", 16'h0001);
        readWord("midrst_w2_old", 16'h0002);

        // Largest legal length fills the whole memory
        applyStimulus(8'h5A);
        applyStimulus(8'h00);
        applyStimulus(8'h01);
        checkFlags("full_len", 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 256; i++) begin
            sendWord(i, 16'(i * 257) ^ 16'h3C5A);
            if (i == 254) checkOutput("full_hold_254", 16'(coreHold), 16'd1);
        end
        checkFlags("full_done", 1'b0, 1'b0, 1'b0, 1'b1);
        readWord("full_w0", 16'h0000);
        readWord("full_w127", 16'h007F);
        readWord("full_w255", 16'h00FF);
        readWord("full_oor", 16'h0100);

        // Oversize length locks into the error state until reset
        applyStimulus(8'h5A);
        applyStimulus(8'h01);
        applyStimulus(8'h01);
        checkFlags("err", 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(8'h5A);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        checkFlags("err_sticky", 1'b1, 1'b0, 1'b1, 1'b0);
        readWord("err_mem_kept", 16'h0005);
        doReset();
        checkFlags("err_cleared", 1'b1, 1'b0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
